// File: rtl/dac_tx_pkg.sv
// dac_tx_pkg: shared frame-state encoding and default frame width for the DAC
// frame transmitter.
package dac_tx_pkg;

  localparam int DAC_FRAME_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } dac_state_e;

endpackage

// File: rtl/dac_sclk_div.sv
// dac_sclk_div: free-running half-period divider. tick marks the last clk cycle
// of each CLK_DIV-cycle half-period; tick_nxt is the same flag one cycle early.
// clr restarts the count so a new frame always begins on a fresh half-period.
module dac_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_nxt
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: restart on clear, wrap after the last cycle of a half-period
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = (cnt_q == LAST_CNT);
  assign tick_nxt = (cnt_d == LAST_CNT);

endmodule

// File: rtl/dac_frame_tx.sv
// dac_frame_tx: serialises one DATA_W-bit DAC word per frame (SETUP, SHIFT,
// HOLD), MSB first, data sampled by the DAC on falling dac_sclk. Requests that
// arrive mid-frame go to a one-deep newest-wins pending slot.
// Optional build macro DAC_SKIP_SAME_EN: an idle request repeating the last
// transmitted word is dropped.
module dac_frame_tx
  import dac_tx_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = DAC_FRAME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [DATA_W-1:0] da_count,
  output logic              dac_sclk,
  output logic              dac_sync_n,
  output logic              dac_din,
  output logic              busy,
  output logic              done
);

  localparam int               BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  dac_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              half_q, half_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] pend_word_q, pend_word_d;
  logic              sclk_q, sclk_d;
  logic              sync_n_q, sync_n_d;
  logic              din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              launch_s;
  logic [DATA_W-1:0] launch_word_s;
  logic              skip_s;
  logic              tick_s;
  logic              tick_nxt_s;
`ifdef DAC_SKIP_SAME_EN
  logic [DATA_W-1:0] last_word_q, last_word_d;
`endif

  dac_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (launch_s),
    .tick     (tick_s),
    .tick_nxt (tick_nxt_s)
  );

  // Next state, frame launch and pending-slot update; the in-flight word is never touched by requests
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    half_d        = half_q;
    pend_vld_d    = pend_vld_q;
    pend_word_d   = pend_word_q;
    launch_s      = 1'b0;
    launch_word_s = da_count;
`ifdef DAC_SKIP_SAME_EN
    last_word_d   = last_word_q;
    skip_s        = (da_count == last_word_q);
`else
    skip_s        = 1'b0;
`endif

    if (set_en && (state_q != IDLE)) begin
      pend_word_d = da_count;
      pend_vld_d  = 1'b1;
    end else begin
      pend_vld_d  = pend_vld_q;
    end

    case (state_q)
      IDLE: begin
        if (set_en && !skip_s) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end
      SETUP: begin
        if (tick_s) begin
          state_d = SHIFT;
        end else begin
          state_d = SETUP;
        end
      end
      SHIFT: begin
        if (tick_s && !half_q) begin
          half_d = 1'b1;
        end else if (tick_s) begin
          half_d    = 1'b0;
          shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          half_d = half_q;
        end
      end
      HOLD: begin
        if (tick_s && set_en) begin
          launch_s      = 1'b1;
          launch_word_s = da_count;
        end else if (tick_s && pend_vld_q) begin
          launch_s      = 1'b1;
          launch_word_s = pend_word_q;
        end else if (tick_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch_s) begin
      state_d    = SETUP;
      shreg_d    = launch_word_s;
      bit_cnt_d  = {BIT_W{1'b0}};
      half_d     = 1'b0;
      pend_vld_d = 1'b0;
`ifdef DAC_SKIP_SAME_EN
      last_word_d = launch_word_s;
`endif
    end else begin
      state_d = state_d;
    end
  end

  // Output values for the coming cycle, decoded from the next state so the pins are flop-driven
  always_comb begin
    sclk_d   = !((state_d == SHIFT) && half_d);
    sync_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == HOLD) && tick_nxt_s;
    if (state_d == SHIFT) begin
      din_d = shreg_d[DATA_W-1];
    end else begin
      din_d = 1'b0;
    end
  end

  // State, datapath and output registers; reset aborts any frame immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= {DATA_W{1'b0}};
      bit_cnt_q   <= {BIT_W{1'b0}};
      half_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_word_q <= {DATA_W{1'b0}};
      sclk_q      <= 1'b1;
      sync_n_q    <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      half_q      <= half_d;
      pend_vld_q  <= pend_vld_d;
      pend_word_q <= pend_word_d;
      sclk_q      <= sclk_d;
      sync_n_q    <= sync_n_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef DAC_SKIP_SAME_EN
  // Last transmitted word, used to suppress repeated idle requests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_word_q <= {DATA_W{1'b0}};
    end else begin
      last_word_q <= last_word_d;
    end
  end
`endif

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_din    = din_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dac_frame_tx.sv
// tb_dac_frame_tx: directed bench for dac_frame_tx (CLK_DIV=4, DATA_W=16).
// A timeline model (frame age counter, pending slot) predicts every output on
// every cycle; literal expectations pin the frame contents and durations.
module tb_dac_frame_tx;

  localparam int CD    = 4;
  localparam int W     = 16;
  localparam int FRAME = (2 * W + 2) * CD;
`ifdef DAC_SKIP_SAME_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         set_en;
  logic [W-1:0] da_count;
  logic         dac_sclk;
  logic         dac_sync_n;
  logic         dac_din;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  dac_frame_tx #(.CLK_DIV(CD), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_en),
    .da_count   (da_count),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_din    (dac_din),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [W-1:0] m_word = '0;
  bit         m_pend_v = 1'b0;
  logic [W-1:0] m_pend_w = '0;
  logic [W-1:0] m_last = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0; m_k = 0; m_pend_v = 1'b0; m_last = '0;
    end else if (m_active && m_k == FRAME - 1) begin
      if (set_en) begin
        m_word = da_count; m_k = 0; m_pend_v = 1'b0; m_last = da_count;
      end else if (m_pend_v) begin
        m_word = m_pend_w; m_k = 0; m_pend_v = 1'b0; m_last = m_pend_w;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      if (m_active) m_k++;
      if (set_en && m_active) begin
        m_pend_v = 1'b1; m_pend_w = da_count;
      end else if (set_en && !(SKIP && da_count == m_last)) begin
        m_active = 1'b1; m_k = 0; m_word = da_count; m_last = da_count;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  logic [4:0] exp_o;
  int bi, ph;
  always @(negedge clk) begin
    exp_o = 5'b11000; // sclk, sync_n, din, busy, done
    if (m_active) begin
      exp_o[1] = 1'b1;
      exp_o[0] = (m_k == FRAME - 1);
      if (m_k < CD) begin
        exp_o[3] = 1'b0;
      end else if (m_k < CD + 2 * W * CD) begin
        bi = (m_k - CD) / (2 * CD);
        ph = (m_k - CD) % (2 * CD);
        exp_o[3] = 1'b0;
        exp_o[4] = (ph < CD);
        exp_o[2] = m_word[W-1-bi];
      end
    end
    check("outputs_vs_model", {27'd0, dac_sclk, dac_sync_n, dac_din, busy, done}, {27'd0, exp_o});
  end

  // ---------------- observation monitor ----------------
  logic [W-1:0] rx_w = '0;
  int rx_n = 0;
  logic prev_sync = 1'b1, prev_sclk = 1'b1;
  logic [W-1:0] fr_word[$];
  int fr_bits[$];
  int busy_cnt = 0, sync_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (!dac_sync_n && prev_sync) begin rx_w = '0; rx_n = 0; end
    if (prev_sclk && !dac_sclk && !dac_sync_n) begin rx_w = {rx_w[W-2:0], dac_din}; rx_n++; end
    if (dac_sync_n && !prev_sync) begin fr_word.push_back(rx_w); fr_bits.push_back(rx_n); end
    busy_cnt += int'(busy);
    sync_cnt += int'(!dac_sync_n);
    done_cnt += int'(done);
    prev_sync = dac_sync_n;
    prev_sclk = dac_sclk;
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [W-1:0] w);
    set_en = 1'b1; da_count = w;
    @(posedge clk); #1;
    set_en = 1'b0;
  endtask

  int b_fr, b_busy, b_sync, b_done;
  bit got;

  initial begin
    rst = 1'b0; set_en = 1'b0; da_count = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_sclk", 32'(dac_sclk), 32'd1);
    check("rst_sync_n", 32'(dac_sync_n), 32'd1);
    check("rst_din", 32'(dac_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    wait_cyc(5);

    // Single write 0x0ABC
    b_fr = fr_word.size(); b_busy = busy_cnt; b_sync = sync_cnt; b_done = done_cnt;
    req(16'h0ABC);
    wait_cyc(200);
    check("single_frame_cnt", 32'(fr_word.size() - b_fr), 32'd1);
    if (fr_word.size() > b_fr) begin
      check("single_word", 32'(fr_word[b_fr]), 32'h0ABC);
      check("single_bits", 32'(fr_bits[b_fr]), 32'd16);
    end
    check("single_sync_low", 32'(sync_cnt - b_sync), 32'd132);
    check("single_busy", 32'(busy_cnt - b_busy), 32'd136);
    check("single_done", 32'(done_cnt - b_done), 32'd1);

    // Back-to-back: 0x1111, 0x2222 at +50, 0x3333 at +60
    b_fr = fr_word.size(); b_busy = busy_cnt; b_done = done_cnt;
    req(16'h1111);
    wait_cyc(49);
    req(16'h2222);
    wait_cyc(9);
    req(16'h3333);
    wait_cyc(350);
    check("b2b_frame_cnt", 32'(fr_word.size() - b_fr), 32'd2);
    if (fr_word.size() > b_fr + 1) begin
      check("b2b_word0", 32'(fr_word[b_fr]), 32'h1111);
      check("b2b_word1", 32'(fr_word[b_fr+1]), 32'h3333);
    end
    check("b2b_busy", 32'(busy_cnt - b_busy), 32'd272);
    check("b2b_done", 32'(done_cnt - b_done), 32'd2);

    // Coincident request on the done cycle
    b_fr = fr_word.size();
    req(16'h0555);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("coinc_done_seen", 32'(got), 32'd1);
    set_en = 1'b1; da_count = 16'h0444;
    @(posedge clk); #1;
    set_en = 1'b0;
    check("coinc_next_sync_n", 32'(dac_sync_n), 32'd0);
    check("coinc_next_busy", 32'(busy), 32'd1);
    wait_cyc(200);
    check("coinc_frame_cnt", 32'(fr_word.size() - b_fr), 32'd2);
    if (fr_word.size() > b_fr + 1) begin
      check("coinc_word0", 32'(fr_word[b_fr]), 32'h0555);
      check("coinc_word1", 32'(fr_word[b_fr+1]), 32'h0444);
    end

    // Reset during bit 7
    req(16'h0F0F);
    wait_cyc(60);
    #2 rst = 1'b0;
    #1;
    check("midrst_sclk", 32'(dac_sclk), 32'd1);
    check("midrst_sync_n", 32'(dac_sync_n), 32'd1);
    check("midrst_din", 32'(dac_din), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    wait_cyc(3);
    rst = 1'b1;
    b_fr = fr_word.size(); b_busy = busy_cnt;
    wait_cyc(200);
    check("midrst_no_resume_busy", 32'(busy_cnt - b_busy), 32'd0);
    check("midrst_no_resume_frames", 32'(fr_word.size() - b_fr), 32'd0);

    // Repeated word, then a different one
    b_fr = fr_word.size();
    req(16'h0ABC);
    wait_cyc(200);
    req(16'h0ABC);
    check("repeat_busy", 32'(busy), SKIP ? 32'd0 : 32'd1);
    wait_cyc(200);
    req(16'h0ABD);
    wait_cyc(200);
    check("repeat_frame_cnt", 32'(fr_word.size() - b_fr), SKIP ? 32'd2 : 32'd3);
    if (fr_word.size() > b_fr + 1) begin
      check("repeat_first", 32'(fr_word[b_fr]), 32'h0ABC);
      check("repeat_last", 32'(fr_word[fr_word.size()-1]), 32'h0ABD);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
